// File: rtl/rng2d_pkg.sv
// Shared definitions for the 2D random coordinate generator and its users.
package rng2d_pkg;

    // Request FSM: wait for request, draw samples, present result.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Default grid geometry.
    localparam int DEF_GRID_W    = 40;
    localparam int DEF_GRID_H    = 30;
    localparam int DEF_X_W       = 6;
    localparam int DEF_Y_W       = 5;
    localparam int DEF_MAX_TRIES = 16;

    // Fallback cell is (0,0); if that cell is excluded, use (1,0) instead.
    localparam int FB_X     = 0;
    localparam int FB_X_ALT = 1;
    localparam int FB_Y     = 0;

endpackage

// File: rtl/coord_check.sv
// Combinational candidate extraction and acceptance test for one random word.
module coord_check #(
    parameter int GRID_W = 40,
    parameter int GRID_H = 30,
    parameter int X_W    = 6,
    parameter int Y_W    = 5
) (
    input  logic [15:0]    i_rnd,
    input  logic           i_blk_en,
    input  logic [X_W-1:0] i_blk_x,
    input  logic [Y_W-1:0] i_blk_y,
    output logic           o_accept,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y
);

    // Bounds are held one bit wider so GRID_W == 2^X_W still fits.
    localparam logic [X_W:0] LIM_X = (X_W+1)'(GRID_W);
    localparam logic [Y_W:0] LIM_Y = (Y_W+1)'(GRID_H);

    logic w_in_x;
    logic w_in_y;
    logic w_blocked;

    assign o_x = i_rnd[X_W-1:0];
    assign o_y = i_rnd[X_W +: Y_W];

    // Range and exclusion compares; the candidate passes only if all hold.
    always_comb begin
        w_in_x    = ({1'b0, o_x} < LIM_X);
        w_in_y    = ({1'b0, o_y} < LIM_Y);
        w_blocked = i_blk_en && (o_x == i_blk_x) && (o_y == i_blk_y);
        o_accept  = w_in_x && w_in_y && !w_blocked;
    end

    // Upper random bits are intentionally discarded.
    generate
        if (X_W + Y_W < 16) begin : g_spare
            logic w_unused_bits;
            assign w_unused_bits = ^i_rnd[15:X_W+Y_W];
        end
    endgenerate

endmodule

// File: rtl/random_coord_gen.sv
// Rejection-sampling coordinate generator: draws random words until one lands
// inside the grid and off the excluded cell, or falls back after MAX_TRIES.
module random_coord_gen
    import rng2d_pkg::*;
#(
    parameter int GRID_W    = DEF_GRID_W,
    parameter int GRID_H    = DEF_GRID_H,
    parameter int X_W       = DEF_X_W,
    parameter int Y_W       = DEF_Y_W,
    parameter int MAX_TRIES = DEF_MAX_TRIES
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [15:0]    rnd_data,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           blk_en,
    input  logic [X_W-1:0] blk_x,
    input  logic [Y_W-1:0] blk_y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [X_W-1:0] out_x,
    output logic [Y_W-1:0] out_y,
    output logic           out_fallback
);

    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

    state_t         r_state;
    state_t         w_next;
    logic [TRY_W-1:0] r_try;
    logic           r_blk_en;
    logic [X_W-1:0] r_blk_x;
    logic [Y_W-1:0] r_blk_y;

    logic           w_accept;
    logic [X_W-1:0] w_cand_x;
    logic [Y_W-1:0] w_cand_y;
    logic           w_last;
    logic           w_req_fire;
    logic           w_out_fire;
    logic [X_W-1:0] w_fb_x;

    coord_check #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) u_check (
        .i_rnd    (rnd_data),
        .i_blk_en (r_blk_en),
        .i_blk_x  (r_blk_x),
        .i_blk_y  (r_blk_y),
        .o_accept (w_accept),
        .o_x      (w_cand_x),
        .o_y      (w_cand_y)
    );

    assign req_ready  = (r_state == ST_IDLE);
    assign out_valid  = (r_state == ST_DONE);
    assign w_req_fire = req_valid && req_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_last     = (r_try == TRY_LAST);
    assign w_fb_x     = (r_blk_en && r_blk_x == X_W'(FB_X) && r_blk_y == Y_W'(FB_Y))
                        ? X_W'(FB_X_ALT) : X_W'(FB_X);

    // Next-state logic: sample until accept or tries exhausted, then hold result.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_req_fire) w_next = ST_SAMPLE;
            ST_SAMPLE: if (w_accept || w_last) w_next = ST_DONE;
            ST_DONE:   if (w_out_fire) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Exclusion snapshot at accept, so later blk_* changes are ignored; try count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blk_en <= 1'b0;
            r_blk_x  <= '0;
            r_blk_y  <= '0;
            r_try    <= '0;
        end else if (w_req_fire) begin
            r_blk_en <= blk_en;
            r_blk_x  <= blk_x;
            r_blk_y  <= blk_y;
            r_try    <= '0;
        end else if (r_state == ST_SAMPLE && !w_accept && !w_last) begin
            r_try    <= r_try + 1'b1;
        end
    end

    // Result registers; only written on leaving SAMPLE, so DONE holds them stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_x        <= '0;
            out_y        <= '0;
            out_fallback <= 1'b0;
        end else if (r_state == ST_SAMPLE) begin
            if (w_accept) begin
                out_x        <= w_cand_x;
                out_y        <= w_cand_y;
                out_fallback <= 1'b0;
            end else if (w_last) begin
                out_x        <= w_fb_x;
                out_y        <= Y_W'(FB_Y);
                out_fallback <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_random_coord_gen.sv
// Scoreboard bench for random_coord_gen. Latency is counted in clock edges
// including the edge that accepts the request.
module tb_random_coord_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rnd_data = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        blk_en = 1'b0;
    logic [5:0]  blk_x = '0;
    logic [4:0]  blk_y = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  out_x;
    logic [4:0]  out_y;
    logic        out_fallback;

    typedef struct {
        logic [5:0] x;
        logic [4:0] y;
        logic       fb;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    random_coord_gen dut (
        .clk          (clk),
        .rst          (rst),
        .rnd_data     (rnd_data),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .blk_en       (blk_en),
        .blk_x        (blk_x),
        .blk_y        (blk_y),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_fallback (out_fallback)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One request: w0 is seen during the first sample cycle, w1 afterwards.
    // hold = cycles of out_ready=0 with noise on inputs before the handshake.
    task automatic run_req(input logic be, input logic [5:0] bx, input logic [4:0] by,
                           input logic [15:0] w0, input logic [15:0] w1,
                           input logic [5:0] ex, input logic [4:0] ey, input logic efb,
                           input int elat, input int hold);
        exp_t e;
        exp_t got;
        int   edges;
        logic busy_rdy;
        e.x = ex; e.y = ey; e.fb = efb; e.lat = elat;
        sb.push_back(e);
        blk_en = be; blk_x = bx; blk_y = by;
        rnd_data = w0;
        req_valid = 1'b1;
        chk("req_ready_idle", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        // Exclusion must already be captured; scramble it.
        blk_en = ~be; blk_x = ~bx; blk_y = ~by;
        edges = 1;
        busy_rdy = 1'b0;
        while (!out_valid && edges < 64) begin
            if (req_ready) busy_rdy = 1'b1;
            @(posedge clk); #1;
            edges++;
            rnd_data = w1;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", out_valid, 1);
            void'(sb.pop_front());
            return;
        end
        chk("req_ready_busy", busy_rdy | req_ready, 0);
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
            return;
        end
        got = sb.pop_front();
        chk("latency", edges, got.lat);
        chk("out_x", out_x, got.x);
        chk("out_y", out_y, got.y);
        chk("out_fallback", out_fallback, got.fb);
        for (int h = 0; h < hold; h++) begin
            rnd_data  = 16'($urandom);
            req_valid = h[0];
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_xyfb", {out_x, out_y, out_fallback}, {got.x, got.y, got.fb});
            chk("hold_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_hs_valid", out_valid, 0);
        chk("post_hs_ready", req_ready, 1);
    endtask

    initial begin
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_xy", {out_x, out_y}, 0);
        chk("rst_fb", out_fallback, 0);
        #11 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_rel_ready", req_ready, 1);

        // Direct accept.
        run_req(1'b0, 6'd0, 5'd0, 16'h0A05, 16'h0A05, 6'd5, 5'd8, 1'b0, 2, 0);
        // x out of range once.
        run_req(1'b0, 6'd0, 5'd0, 16'h003F, 16'h0A05, 6'd5, 5'd8, 1'b0, 3, 0);
        // y out of range once.
        run_req(1'b0, 6'd0, 5'd0, 16'h0780, 16'h0A05, 6'd5, 5'd8, 1'b0, 3, 0);
        // x == GRID_W rejected, then corner (39,29) accepted.
        run_req(1'b0, 6'd0, 5'd0, 16'h0028, 16'h0767, 6'd39, 5'd29, 1'b0, 3, 0);
        // Excluded cell always drawn: fallback (0,0).
        run_req(1'b1, 6'd5, 5'd8, 16'h0A05, 16'h0A05, 6'd0, 5'd0, 1'b1, 17, 0);
        // Always out of range with (0,0) excluded: fallback (1,0).
        run_req(1'b1, 6'd0, 5'd0, 16'hFFFF, 16'hFFFF, 6'd1, 5'd0, 1'b1, 17, 0);
        // Exclusion active but not hit.
        run_req(1'b1, 6'd0, 5'd0, 16'h0A05, 16'h0A05, 6'd5, 5'd8, 1'b0, 2, 0);
        // Backpressure for 5 cycles.
        run_req(1'b0, 6'd0, 5'd0, 16'h003F, 16'h0A05, 6'd5, 5'd8, 1'b0, 3, 5);

        // Asynchronous reset in the middle of sampling.
        rnd_data  = 16'h003F;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_xy", {out_x, out_y}, 0);
        chk("arst_fb", out_fallback, 0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_rel_ready", req_ready, 1);
        chk("arst_rel_valid", out_valid, 0);
        run_req(1'b0, 6'd0, 5'd0, 16'h0A05, 16'h0A05, 6'd5, 5'd8, 1'b0, 2, 0);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
